// File: rtl/dct_2d_stream_if.sv
// rtl/dct_2d_stream_if.sv - Row-stream handshake bundle between block fetcher, dct_2d_stream and quantiser
// slave is the DCT side; master is the upstream/downstream environment side.
interface dct_2d_stream_if #(
    parameter int N      = 8,
    parameter int PIX_W  = 8,
    parameter int COEF_W = 12
);
    logic                 in_valid;
    logic                 in_ready;
    logic [N*PIX_W-1:0]   in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [N*COEF_W-1:0]  out_data;
    logic                 out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/dct_2d_stream.sv
// rtl/dct_2d_stream.sv - NxN 2-D DCT sequencer: row pass, optional column pass, row-wise output
// Both passes share one external 1-D core; a tag pipeline routes each returning result to its row/column.
module dct_2d_stream #(
    parameter int N           = 8,
    parameter int PIX_W       = 8,
    parameter int COEF_W      = 12,
    parameter int CORE_LAT    = 1,
    parameter int LEVEL_SHIFT = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 mode_2d,
    dct_2d_stream_if.slave       io,
    output logic                 core_valid,
    output logic [N*COEF_W-1:0]  core_in,
    input  logic [N*COEF_W-1:0]  core_out,
    output logic                 busy
);
    localparam int AW = $clog2(N);
    localparam int IW = $clog2(N + 1);
    localparam logic [AW-1:0] LAST_ROW  = AW'(N - 1);
    localparam logic [IW-1:0] ISSUE_END = IW'(N);
    localparam logic [COEF_W-1:0] SHIFT = (LEVEL_SHIFT != 0) ? COEF_W'(1 << (PIX_W - 1)) : '0;

    typedef enum logic [1:0] {S_LOAD, S_ROW, S_COL, S_OUT} state_t;

    state_t state, state_next;

    logic [AW-1:0]     cnt;     // rows captured in LOAD, rows sent in OUT
    logic [IW-1:0]     icnt;    // vectors issued in the current pass
    logic              mode_q;
    logic [PIX_W-1:0]  x_buf [N][N];
    logic [COEF_W-1:0] t_buf [N][N];
    logic [COEF_W-1:0] o_buf [N][N];

    logic [CORE_LAT-1:0]         tag_v;
    logic [CORE_LAT-1:0][AW-1:0] tag_i;

    logic          in_fire;
    logic          out_fire;
    logic          issue;
    logic          res_v;
    logic [AW-1:0] res_i;
    logic [AW-1:0] issue_i;

    assign res_v   = tag_v[CORE_LAT-1];
    assign res_i   = tag_i[CORE_LAT-1];
    assign issue_i = icnt[AW-1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        in_fire      = 1'b0;
        out_fire     = 1'b0;
        issue        = 1'b0;
        io.in_ready  = 1'b0;
        io.out_valid = 1'b0;
        io.out_last  = 1'b0;
        busy         = 1'b0;
        if (!reset) begin
            busy = (state != S_LOAD) || (cnt != '0);
            case (state)
                S_LOAD: begin
                    io.in_ready = 1'b1;
                    in_fire     = io.in_valid;
                    if (in_fire && cnt == LAST_ROW) begin
                        state_next = S_ROW;
                    end
                end
                S_ROW, S_COL: begin
                    issue = (icnt != ISSUE_END);
                    // The pass ends on the write-back of its last vector, not on its issue.
                    if (res_v && res_i == LAST_ROW) begin
                        state_next = (state == S_COL || !mode_q) ? S_OUT : S_COL;
                    end
                end
                S_OUT: begin
                    io.out_valid = 1'b1;
                    io.out_last  = (cnt == LAST_ROW);
                    out_fire     = io.out_ready;
                    if (out_fire && cnt == LAST_ROW) begin
                        state_next = S_LOAD;
                    end
                end
                default: state_next = S_LOAD;
            endcase
        end
        core_valid = issue;
    end

    always_comb begin
        core_in     = '0;
        io.out_data = '0;
        for (int k = 0; k < N; k++) begin
            if (issue) begin
                core_in[k*COEF_W +: COEF_W] = (state == S_ROW)
                    ? COEF_W'(x_buf[issue_i][AW'(k)]) - SHIFT
                    : t_buf[AW'(k)][issue_i];
            end
            if (io.out_valid) begin
                io.out_data[k*COEF_W +: COEF_W] = mode_q ? o_buf[cnt][AW'(k)] : t_buf[cnt][AW'(k)];
            end
        end
    end

    always_ff @(posedge clock) begin
        tag_i <= (CORE_LAT*AW)'({tag_i, issue_i});
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt    <= '0;
            icnt   <= '0;
            mode_q <= 1'b0;
            tag_v  <= '0;
        end else begin
            tag_v <= CORE_LAT'({tag_v, issue});
            if (in_fire) begin
                for (int c = 0; c < N; c++) begin
                    x_buf[cnt][AW'(c)] <= io.in_data[c*PIX_W +: PIX_W];
                end
                if (cnt == '0) begin
                    mode_q <= mode_2d;
                end
            end
            if (in_fire || out_fire) begin
                cnt <= (cnt == LAST_ROW) ? '0 : cnt + 1'b1;
            end
            if (state_next != state) begin
                icnt <= '0;
            end else if (issue) begin
                icnt <= icnt + 1'b1;
            end
            // Row results land as T rows; column results land transposed into the output buffer.
            if (res_v) begin
                for (int k = 0; k < N; k++) begin
                    if (state == S_ROW) begin
                        t_buf[res_i][AW'(k)] <= core_out[k*COEF_W +: COEF_W];
                    end else begin
                        o_buf[AW'(k)][res_i] <= core_out[k*COEF_W +: COEF_W];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_dct_2d_stream.sv
// tb/tb_dct_2d_stream.sv - Self-checking bench for dct_2d_stream (8x8 lat 1 shifted, 4x4 lat 4 unshifted)
module tb_dct_2d_stream;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    typedef struct {
        int inst;   // 0: N=8 CORE_LAT=1 LEVEL_SHIFT=1, 1: N=4 CORE_LAT=4 LEVEL_SHIFT=0
        bit mode;
        bit rev;    // core model reverses element order
        int pat;    // 0: all 200, 1: all 0, 2: r*N+c, 3: random
        bit bp;
        bit hold;   // keep in_valid high while the block is busy
        int lat;    // cycles from last accepted row to first out_valid
        int e00;    // expected out[0][0] as 12-bit code, -1 = not tabulated
    } vec_t;

    int errors = 0;
    int checks = 0;

    bit          sel;
    logic        drv_valid, drv_ready, drv_mode, drv_rev;
    logic [63:0] drv_data;

    dct_2d_stream_if #(.N(8), .PIX_W(8), .COEF_W(12)) ifa ();
    dct_2d_stream_if #(.N(4), .PIX_W(8), .COEF_W(12)) ifb ();

    logic        core_valid_a, busy_a, core_valid_b, busy_b;
    logic [95:0] core_in_a, core_out_a, pipe_a;
    logic [47:0] core_in_b, core_out_b;
    logic [47:0] pipe_b [4];

    assign ifa.in_valid  = drv_valid & ~sel;
    assign ifa.in_data   = drv_data;
    assign ifa.out_ready = drv_ready & ~sel;
    assign ifb.in_valid  = drv_valid & sel;
    assign ifb.in_data   = drv_data[31:0];
    assign ifb.out_ready = drv_ready & sel;

    dct_2d_stream #(.N(8), .PIX_W(8), .COEF_W(12), .CORE_LAT(1), .LEVEL_SHIFT(1)) u_dut_a (
        .clock(clock), .reset(reset), .mode_2d(drv_mode), .io(ifa),
        .core_valid(core_valid_a), .core_in(core_in_a), .core_out(core_out_a), .busy(busy_a)
    );

    dct_2d_stream #(.N(4), .PIX_W(8), .COEF_W(12), .CORE_LAT(4), .LEVEL_SHIFT(0)) u_dut_b (
        .clock(clock), .reset(reset), .mode_2d(drv_mode), .io(ifb),
        .core_valid(core_valid_b), .core_in(core_in_b), .core_out(core_out_b), .busy(busy_b)
    );

    // 1-D core stand-ins: pure delay lines, optionally reversing element order.
    always @(posedge clock) begin
        pipe_a    <= core_in_a;
        pipe_b[0] <= core_in_b;
        for (int i = 1; i < 4; i++) pipe_b[i] <= pipe_b[i-1];
    end

    always_comb begin
        core_out_a = '0;
        core_out_b = '0;
        for (int k = 0; k < 8; k++)
            core_out_a[k*12 +: 12] = drv_rev ? pipe_a[(7-k)*12 +: 12] : pipe_a[k*12 +: 12];
        for (int k = 0; k < 4; k++)
            core_out_b[k*12 +: 12] = drv_rev ? pipe_b[3][(3-k)*12 +: 12] : pipe_b[3][k*12 +: 12];
    end

    logic        m_in_ready, m_out_valid, m_out_last, m_core_valid, m_busy;
    logic [95:0] m_out_data;

    always_comb begin
        if (!sel) begin
            m_in_ready = ifa.in_ready;  m_out_valid = ifa.out_valid; m_out_last = ifa.out_last;
            m_out_data = ifa.out_data;  m_core_valid = core_valid_a; m_busy = busy_a;
        end else begin
            m_in_ready = ifb.in_ready;  m_out_valid = ifb.out_valid; m_out_last = ifb.out_last;
            m_out_data = 96'(ifb.out_data); m_core_valid = core_valid_b; m_busy = busy_b;
        end
    end

    int px [8][8];
    int exp_blk [8][8];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic fill_px(input int pat, input int n);
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                case (pat)
                    0:       px[r][c] = 200;
                    1:       px[r][c] = 0;
                    2:       px[r][c] = r * n + c;
                    default: px[r][c] = int'($urandom_range(0, 255));
                endcase
    endtask

    // Reference: shift, 1-D transform of every row, then of every column of that result.
    task automatic build_exp(input int n, input int off, input bit m2, input bit rev);
        int v [8];
        int t [8][8];
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) v[c] = px[r][c] - off;
            for (int c = 0; c < n; c++) t[r][c] = rev ? v[n-1-c] : v[c];
        end
        for (int c = 0; c < n; c++) begin
            for (int k = 0; k < n; k++) v[k] = t[k][c];
            for (int r = 0; r < n; r++) exp_blk[r][c] = m2 ? (rev ? v[n-1-r] : v[r]) : t[r][c];
        end
    endtask

    function automatic logic [95:0] exp_row(input int r, input int n);
        logic [95:0] d;
        d = '0;
        for (int c = 0; c < n; c++) d[c*12 +: 12] = 12'(exp_blk[r][c]);
        return d;
    endfunction

    function automatic logic [63:0] pack_row(input int r, input int n);
        logic [63:0] d;
        d = '0;
        for (int c = 0; c < n; c++) d[c*8 +: 8] = 8'(px[r][c]);
        return d;
    endfunction

    task automatic load_block(input int n, input bit mode);
        for (int r = 0; r < n; r++) begin
            drv_valid = 1'b1;
            drv_data  = pack_row(r, n);
            drv_mode  = (r == 0) ? mode : ~mode;
            #1;
            chk("in_ready_load", m_in_ready, 1);
            if (r == 1) chk("busy_load", m_busy, 1);
            tick();
        end
    endtask

    task automatic run_block(input vec_t v);
        int n, k, cv_cnt, rdy_bad, s;
        logic [95:0] held, first;
        n = (v.inst != 0) ? 4 : 8;
        drv_valid = 1'b0;
        drv_ready = 1'b0;
        sel       = (v.inst != 0);
        drv_rev   = v.rev;
        first     = '0;
        fill_px(v.pat, n);
        build_exp(n, (v.inst != 0) ? 0 : 128, v.mode, v.rev);
        load_block(n, v.mode);

        drv_valid = v.hold;
        drv_data  = {$urandom, $urandom};
        drv_ready = 1'b1;
        #1;
        chk("in_ready_fall", m_in_ready, 0);
        k = 0; cv_cnt = 0; rdy_bad = 0;
        while (!m_out_valid && k < 200) begin
            if (m_core_valid) cv_cnt++;
            if (m_in_ready) rdy_bad++;
            tick();
            k++;
        end
        chk("first_out_latency", k + 1, v.lat);
        chk("core_issues", cv_cnt, v.mode ? 2 * n : n);

        for (int r = 0; r < n; r++) begin
            s = v.bp ? int'($urandom_range(0, 2)) : 0;
            if (s > 0) begin
                drv_ready = 1'b0;
                held = m_out_data;
                repeat (s) begin
                    tick();
                    if (m_in_ready) rdy_bad++;
                    chk("stall_valid", m_out_valid, 1);
                    chk("stall_data", m_out_data, held);
                end
                drv_ready = 1'b1;
                #1;
            end
            chk("out_valid", m_out_valid, 1);
            chk("out_data", m_out_data, exp_row(r, n));
            chk("out_last", m_out_last, r == n - 1);
            if (r == 0) first = m_out_data;
            if (v.hold) drv_data = {$urandom, $urandom};
            if (r == n - 1) drv_valid = 1'b0;
            tick();
        end
        chk("in_ready_low_busy", rdy_bad, 0);
        drv_ready = 1'b0;
        #1;
        chk("out_valid_end", m_out_valid, 0);
        chk("in_ready_return", m_in_ready, 1);
        if (v.e00 >= 0) chk("elem00", {84'b0, first[11:0]}, 96'(v.e00));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t tbl [9];
        vec_t fresh;
        tbl[0] = '{0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 19, 72};
        tbl[1] = '{0, 1'b1, 1'b0, 1, 1'b0, 1'b0, 19, 3968};
        tbl[2] = '{0, 1'b1, 1'b1, 2, 1'b0, 1'b0, 19, 4031};
        tbl[3] = '{0, 1'b0, 1'b1, 2, 1'b0, 1'b0, 10, 3975};
        tbl[4] = '{0, 1'b1, 1'b1, 3, 1'b1, 1'b1, 19, -1};
        tbl[5] = '{1, 1'b1, 1'b0, 2, 1'b0, 1'b1, 17, 0};
        tbl[6] = '{1, 1'b1, 1'b1, 2, 1'b1, 1'b1, 17, 15};
        tbl[7] = '{1, 1'b0, 1'b1, 3, 1'b1, 1'b0, 9, -1};
        tbl[8] = '{0, 1'b0, 1'b0, 3, 1'b1, 1'b0, 10, -1};
        fresh  = '{0, 1'b1, 1'b1, 3, 1'b0, 1'b0, 19, -1};

        sel = 1'b0; drv_valid = 1'b0; drv_ready = 1'b0;
        drv_mode = 1'b0; drv_rev = 1'b0; drv_data = '0;

        repeat (3) tick();
        chk("rst_in_ready", m_in_ready, 0);
        chk("rst_core_valid", m_core_valid, 0);
        chk("rst_out_valid", m_out_valid, 0);
        chk("rst_out_last", m_out_last, 0);
        chk("rst_busy", m_busy, 0);
        chk("rst_out_data", m_out_data, 0);
        chk("rst_core_in", core_in_a, 0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", m_in_ready, 1);

        for (int i = 0; i < 9; i++) run_block(tbl[i]);

        // Abort a block after three row-pass issues, then prove a fresh block is clean.
        sel = 1'b0;
        drv_rev = 1'b0;
        fill_px(3, 8);
        load_block(8, 1'b1);
        drv_valid = 1'b0;
        #1;
        chk("abort_issue_started", m_core_valid, 1);
        repeat (3) tick();
        reset = 1'b1;
        #1;
        chk("abort_core_valid_in_reset", m_core_valid, 0);
        chk("abort_in_ready_in_reset", m_in_ready, 0);
        tick();
        reset = 1'b0;
        #1;
        chk("abort_core_valid", m_core_valid, 0);
        chk("abort_out_valid", m_out_valid, 0);
        chk("abort_in_ready", m_in_ready, 1);
        chk("abort_busy", m_busy, 0);
        run_block(fresh);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
